// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - HI/LO multiply/divide issue sequencer with ID stall
module mdu_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic        flush,
  input  logic [3:0]  id_mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic        proto_err
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [7:0] MUL_CNT = 8'(MUL_CYCLES);
  localparam logic [7:0] DIV_CNT = 8'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        done_q;
  logic        proto_err_q;

  logic        fire;
  logic        is_idle;
  logic        op_muldiv;
  logic        op_known;

  logic        accept_mul, accept_div, commit, violation, write_hi, write_lo;

  // Datapath for the result that will be parked in pend_hi/pend_lo
  logic [63:0] mul_a, mul_b, product;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign fire      = op_valid & ~flush;
  assign is_idle   = (state_q == S_IDLE);
  assign op_muldiv = (op >= OP_MULT) && (op <= OP_DIVU);
  assign op_known  = (op >= OP_MULT) && (op <= OP_MTLO);

  // Signed multiply done as a 64-bit product of sign-extended operands
  assign mul_a   = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
  assign mul_b   = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
  assign product = mul_a * mul_b;

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = b_neg ? (32'd0 - b) : b;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d    = state_q;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    commit     = 1'b0;
    violation  = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              accept_mul = 1'b1;
              state_d    = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              accept_div = 1'b1;
              state_d    = S_DIV;
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        // The commit edge is still busy, so an op issued there is a violation too
        if (fire && op_known) violation = 1'b1;
        if (count_q == 8'd1) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latency counter: loaded on accept, counts down while a mult/div is in flight
  always_ff @(posedge clk) begin
    if (reset)                count_q <= 8'd0;
    else if (accept_mul)      count_q <= MUL_CNT;
    else if (accept_div)      count_q <= DIV_CNT;
    else if (!is_idle)        count_q <= count_q - 8'd1;
  end

  // Pending result; divide-by-zero parks the current HI/LO so commit leaves them unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else if (accept_mul) begin
      pend_hi_q <= product[63:32];
      pend_lo_q <= product[31:0];
    end else if (accept_div) begin
      if (b == 32'd0) begin
        pend_hi_q <= hi_q;
        pend_lo_q <= lo_q;
      end else begin
        pend_hi_q <= rem;
        pend_lo_q <= quot;
      end
    end
  end

  // Architectural HI/LO: written by commit or by mthi/mtlo in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (commit) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
      if (write_hi) hi_q <= a;
      if (write_lo) lo_q <= a;
    end
  end

  // Completion pulse and sticky protocol error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      done_q      <= commit;
      proto_err_q <= proto_err_q | violation;
    end
  end

  // Move-from read port and ID stall request
  always_comb begin
    rd_data = 32'd0;
    if (fire && is_idle && op == OP_MFHI) rd_data = hi_q;
    if (fire && is_idle && op == OP_MFLO) rd_data = lo_q;
  end

  assign stall     = (id_mdu_op != 4'd0) & (~is_idle | (is_idle & fire & op_muldiv));
  assign busy      = ~is_idle;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - directed table and sequence bench for mdu_issue_ctrl
module tb_mdu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic        flush;
  logic [3:0]  id_mdu_op;
  logic [31:0] a, b;
  logic [31:0] rd_data, hi, lo;
  logic        busy, done, stall, proto_err;

  int checks = 0;
  int errors = 0;

  mdu_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .flush(flush),
    .id_mdu_op(id_mdu_op), .a(a), .b(b), .rd_data(rd_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        op_valid;
    logic [3:0]  op;
    logic        flush;
    logic [3:0]  id_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_rd;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_stall;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic f,
                       input logic [3:0] id, input logic [31:0] aa, input logic [31:0] bb);
    op_valid  = v;
    op        = o;
    flush     = f;
    id_mdu_op = id;
    a         = aa;
    b         = bb;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Counts edges from the first busy cycle until busy falls, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Issue a mult/div in one cycle, then let it run to the done cycle
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(1'b1, o, 1'b0, 4'd0, aa, bb);
    #1;
    chk({name, "_accept_busy"}, 32'(busy), 32'd0);
    tick();
    idle_in();
    wait_idle(n);
    chk({name, "_cycles"}, n, exp_cycles);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_proto_err", 32'(proto_err), 32'd0);

    //          valid op     flush id    a               b     rd              hi              lo     stall
    tbl[0]  = '{1'b0, 4'd0,  1'b0, 4'd0, 32'd0,          32'd0, 32'd0,          32'd0,          32'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'd7,  1'b0, 4'd0, 32'h1234,       32'd0, 32'd0,          32'd0,          32'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'd5,  1'b0, 4'd0, 32'd0,          32'd0, 32'h1234,       32'h1234,       32'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'd8,  1'b0, 4'd0, 32'd9,          32'd0, 32'd0,          32'h1234,       32'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'd6,  1'b1, 4'd0, 32'd0,          32'd0, 32'd0,          32'h1234,       32'd9, 1'b0};
    tbl[5]  = '{1'b1, 4'd6,  1'b0, 4'd0, 32'd0,          32'd0, 32'd9,          32'h1234,       32'd9, 1'b0};
    tbl[6]  = '{1'b1, 4'd0,  1'b0, 4'd0, 32'd77,         32'd0, 32'd0,          32'h1234,       32'd9, 1'b0};
    tbl[7]  = '{1'b1, 4'd12, 1'b0, 4'd0, 32'd55,         32'd0, 32'd0,          32'h1234,       32'd9, 1'b0};
    tbl[8]  = '{1'b0, 4'd5,  1'b0, 4'd0, 32'd0,          32'd0, 32'd0,          32'h1234,       32'd9, 1'b0};
    tbl[9]  = '{1'b1, 4'd7,  1'b1, 4'd0, 32'hDEAD,       32'd0, 32'd0,          32'h1234,       32'd9, 1'b0};
    tbl[10] = '{1'b1, 4'd5,  1'b0, 4'd0, 32'd0,          32'd0, 32'h1234,       32'h1234,       32'd9, 1'b0};
    tbl[11] = '{1'b1, 4'd7,  1'b0, 4'd6, 32'h1234,       32'd0, 32'd0,          32'h1234,       32'd9, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op_valid, tbl[i].op, tbl[i].flush, tbl[i].id_op, tbl[i].a, tbl[i].b);
      #1;
      chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].exp_rd);
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].exp_lo);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      tick();
    end
    idle_in();

    // mult -3 * 7: busy for exactly five cycles, one-cycle done, done cycle accepts mthi
    drive(1'b1, 4'd1, 1'b0, 4'd0, 32'hFFFF_FFFD, 32'd7);
    tick();
    idle_in();
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("mult_busy_c%0d", i), 32'(busy), 32'd1);
      chk($sformatf("mult_nodone_c%0d", i), 32'(done), 32'd0);
      chk($sformatf("mult_hi_hold_c%0d", i), hi, 32'h1234);
      tick();
    end
    chk("mult_busy_end", 32'(busy), 32'd0);
    chk("mult_done", 32'(done), 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    drive(1'b1, 4'd7, 1'b0, 4'd0, 32'hABCD, 32'd0);
    tick();
    idle_in();
    chk("mult_done_pulse_width", 32'(done), 32'd0);
    chk("done_cycle_mthi", hi, 32'hABCD);

    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    // divu 100/7 with a dependent mflo held in ID
    drive(1'b1, 4'd4, 1'b0, 4'd6, 32'd100, 32'd7);
    #1;
    chk("divu_accept_stall", 32'(stall), 32'd1);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd6, 32'd0, 32'd0);
    n = 1;
    while (stall && n < 50) begin
      tick();
      n++;
    end
    chk("divu_stall_cycles", n, 32'd11);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    idle_in();
    tick();

    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // divide by zero leaves HI/LO as written by mthi/mtlo
    drive(1'b1, 4'd7, 1'b0, 4'd0, 32'd5, 32'd0);
    tick();
    drive(1'b1, 4'd8, 1'b0, 4'd0, 32'd9, 32'd0);
    tick();
    run_op("div_zero", 4'd3, 32'd123, 32'd0, 10, 32'd5, 32'd9);
    chk("no_proto_err_yet", 32'(proto_err), 32'd0);

    // mult issued during a div: ignored, sticky error, div result only
    drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd100, 32'd7);
    tick();
    idle_in();
    tick();
    drive(1'b1, 4'd1, 1'b0, 4'd0, 32'd3, 32'd3);
    tick();
    idle_in();
    chk("proto_err_set", 32'(proto_err), 32'd1);
    wait_idle(n);
    chk("proto_remaining_cycles", n, 32'd8);
    chk("proto_hi", hi, 32'd2);
    chk("proto_lo", lo, 32'd14);
    tick();
    chk("proto_no_mult_started", 32'(busy), 32'd0);
    chk("proto_err_sticky", 32'(proto_err), 32'd1);

    // reset at busy cycle 3 of a div aborts it
    drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd100, 32'd7);
    tick();
    idle_in();
    tick();
    tick();
    chk("abort_busy_c3", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_proto_err", 32'(proto_err), 32'd0);
    tick();
    chk("abort_no_late_done", 32'(done), 32'd0);
    chk("abort_still_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
